// File: rtl/dmem_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_store_buffer_pkg
// Brief  : Shared widths and the store-buffer entry type for dmem_store_buffer.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_store_buffer_pkg;

  localparam int SB_ADDR_W = 8;
  localparam int SB_DEPTH  = 4;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] widx;
    logic [31:0]          data;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dmem_store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module : sb_fifo
// Brief  : Circular store FIFO with youngest-match forwarding lookup.
// Rev    : 1.0  initial release
// ============================================================================
module sb_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  sb_entry_t            push_entry_i,
  input  logic                 pop_i,
  output sb_entry_t            head_o,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic [SB_ADDR_W-1:0] lookup_widx_i,
  output logic                 hit_o,
  output logic [31:0]          hit_data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t          entry_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + PTR_W'(1);
    if (push_i) tail_d = tail_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push_i && pop_i) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset: validity comes only from head/count.
  always_ff @(posedge clk_i) begin
    if (push_i) entry_q[tail_q] <= push_entry_i;
  end

  assign head_o  = entry_q[head_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Walk oldest to youngest so the youngest valid match is the one kept.
  always_comb begin
    logic [PTR_W-1:0] w_ptr;
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ptr = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (entry_q[w_ptr].widx == lookup_widx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entry_q[w_ptr].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : dmem_store_buffer
// Brief  : Data memory with a posted-write store buffer draining to mem_data.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int ADDR_W    = SB_ADDR_W,
  parameter int DEPTH     = SB_DEPTH,
  parameter int WRITE_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        sb_empty
);

  localparam int LAT_W = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;

  logic [31:0]       mem_data [2**ADDR_W];
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

  logic [ADDR_W-1:0] w_widx;
  sb_entry_t         w_push_entry;
  sb_entry_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [31:0]       w_hit_data;
  logic              w_drain_done;
  logic              w_push;
  logic              w_unused;

  assign w_widx       = address[ADDR_W+1:2];
  assign w_push_entry = '{widx: w_widx, data: write_data};
  // mem_read only qualifies the CPU's use of read_data; the lookup is always live.
  assign w_unused     = ^{mem_read, address[31:ADDR_W+2], address[1:0]};

  assign w_drain_done = !w_empty && (lat_cnt_q == LAT_W'(WRITE_LAT-1));
  assign stall        = mem_write && w_full && !w_drain_done;
  assign w_push       = mem_write && !stall;
  assign sb_empty     = w_empty;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (reset),
    .push_i        (w_push),
    .push_entry_i  (w_push_entry),
    .pop_i         (w_drain_done),
    .head_o        (w_head),
    .full_o        (w_full),
    .empty_o       (w_empty),
    .lookup_widx_i (w_widx),
    .hit_o         (w_hit),
    .hit_data_o    (w_hit_data)
  );

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (w_empty || w_drain_done) lat_cnt_d = '0;
    else                         lat_cnt_d = lat_cnt_q + LAT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lat_cnt_q <= '0;
    else       lat_cnt_q <= lat_cnt_d;
  end

  // The array survives reset; an asynchronous reset also clears count, so no drain fires.
  always_ff @(posedge clk) begin
    if (w_drain_done) mem_data[w_head.widx] <= w_head.data;
  end

  assign read_data = w_hit ? w_hit_data : mem_data[w_widx];

endmodule
`default_nettype wire
